iq_mixer_cic: RTL and testbench

//  Downstream consumer of the 1-bit NCO. Mixes 1-bit RF comparator input with NCO square-wave LO
//  (sin/cos) into I/Q. Decimates each branch through a 3rd-order CIC (M=1) and emits signed

---
 rtl/iq_mixer_cic.sv | 109 ++++++++++
 tb/tb_iq_mixer_cic.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/iq_mixer_cic.sv
// iq_mixer_cic: 1-bit RF x square-wave LO mixer into I/Q with 3rd-order CIC decimators.
// Combs run one stage per cycle after each decimation strobe; the first three results are suppressed.
module iq_mixer_cic #(
    parameter int DECIMATION = 4096,
    parameter int ACC_WIDTH  = 38,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rf_in,
    input  logic                        lo_sin,
    input  logic                        lo_cos,
    output logic signed [OUT_WIDTH-1:0] i_out,
    output logic signed [OUT_WIDTH-1:0] q_out,
    output logic                        out_valid
);
    localparam int CNT_W = $clog2(DECIMATION);

    if (DECIMATION < 4 || DECIMATION > 65536) begin : g_bad_dec
        $error("iq_mixer_cic: DECIMATION %0d outside 4..65536", DECIMATION);
    end
    if (ACC_WIDTH < 3 * CNT_W + 2) begin : g_bad_acc
        $error("iq_mixer_cic: ACC_WIDTH %0d below 3*clog2(R)+2", ACC_WIDTH);
    end
    if (OUT_WIDTH < 1 || OUT_WIDTH > ACC_WIDTH) begin : g_bad_out
        $error("iq_mixer_cic: OUT_WIDTH %0d outside 1..ACC_WIDTH", OUT_WIDTH);
    end

    // branch index 0 is I (mixed with cos), 1 is Q (mixed with sin)
    logic [2:0]                 in_q;
    logic [1:0]                 bit_q, bit_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [2:0]                 ph_q;
    logic [1:0]                 warm_q;
    logic                       strobe, publish;
    logic signed [ACC_WIDTH-1:0] ext  [2];
    logic signed [ACC_WIDTH-1:0] int1_q [2];
    logic signed [ACC_WIDTH-1:0] int2_q [2];
    logic signed [ACC_WIDTH-1:0] int3_q [2];
    logic signed [ACC_WIDTH-1:0] x_q  [2];
    logic signed [ACC_WIDTH-1:0] c1_q [2];
    logic signed [ACC_WIDTH-1:0] c2_q [2];
    logic signed [ACC_WIDTH-1:0] d1_q [2];
    logic signed [ACC_WIDTH-1:0] d2_q [2];
    logic signed [ACC_WIDTH-1:0] d3_q [2];
    logic signed [ACC_WIDTH-1:0] c3   [2];

    always_comb begin
        bit_d   = {~(in_q[2] ^ in_q[1]), ~(in_q[2] ^ in_q[0])};
        strobe  = cnt_q == CNT_W'(DECIMATION - 1);
        cnt_d   = strobe ? '0 : cnt_q + CNT_W'(1);
        publish = ph_q[2] && warm_q == 2'd3;
        for (int b = 0; b < 2; b++) begin
            ext[b] = {{(ACC_WIDTH - 1){~bit_q[b]}}, 1'b1};
            c3[b]  = c2_q[b] - d3_q[b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q      <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            ph_q      <= '0;
            warm_q    <= '0;
            out_valid <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
            for (int b = 0; b < 2; b++) begin
                int1_q[b] <= '0;
                int2_q[b] <= '0;
                int3_q[b] <= '0;
                x_q[b]    <= '0;
                c1_q[b]   <= '0;
                c2_q[b]   <= '0;
                d1_q[b]   <= '0;
                d2_q[b]   <= '0;
                d3_q[b]   <= '0;
            end
        end else begin
            in_q      <= {rf_in, lo_sin, lo_cos};
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            ph_q      <= {ph_q[1:0], strobe};
            out_valid <= publish;
            if (ph_q[2] && warm_q != 2'd3) warm_q <= warm_q + 2'd1;
            // integrators wrap modulo 2^ACC_WIDTH; the comb differences undo the wrap
            for (int b = 0; b < 2; b++) begin
                int1_q[b] <= int1_q[b] + ext[b];
                int2_q[b] <= int2_q[b] + int1_q[b];
                int3_q[b] <= int3_q[b] + int2_q[b];
                if (strobe) x_q[b] <= int3_q[b];
                if (ph_q[0]) begin
                    c1_q[b] <= x_q[b] - d1_q[b];
                    d1_q[b] <= x_q[b];
                end
                if (ph_q[1]) begin
                    c2_q[b] <= c1_q[b] - d2_q[b];
                    d2_q[b] <= c1_q[b];
                end
                if (ph_q[2]) d3_q[b] <= c2_q[b];
            end
            if (publish) begin
                i_out <= c3[0][ACC_WIDTH-1 -: OUT_WIDTH];
                q_out <= c3[1][ACC_WIDTH-1 -: OUT_WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_iq_mixer_cic.sv
// tb_iq_mixer_cic: checks iq_mixer_cic against an impulse-response model of the mixer + CIC.
module tb_iq_mixer_cic;
    localparam int D  = 8;
    localparam int AW = 11;
    localparam int OW = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rf_in = 1'b0;
    logic lo_sin = 1'b0;
    logic lo_cos = 1'b0;
    logic signed [OW-1:0] i_out, q_out;
    logic out_valid;

    int checks = 0;
    int errors = 0;
    int e = 0;
    int ui[$];
    int uq[$];
    logic [2:0] hist[$];
    logic exp_v = 1'b0;
    logic [OW-1:0] exp_i = '0;
    logic [OW-1:0] exp_q = '0;

    iq_mixer_cic #(.DECIMATION(D), .ACC_WIDTH(AW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n), .rf_in(rf_in), .lo_sin(lo_sin), .lo_cos(lo_cos),
        .i_out(i_out), .q_out(q_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic longint tri_n(input longint l);
        return l > 0 ? l * (l + 1) / 2 : 0;
    endfunction

    // decimated output n = products convolved with the 3rd-order CIC kernel (third difference of a triangular-number ramp)
    function automatic longint cic(input int n, input bit q);
        longint acc = 0;
        longint l;
        for (int k = (D * (n - 4) > 1 ? D * (n - 4) : 1); k <= D * n - 3; k++) begin
            l = longint'(D * n - 2 - k);
            acc += longint'(q ? uq[k-1] : ui[k-1]) *
                   (tri_n(l) - 3 * tri_n(l - D) + 3 * tri_n(l - 2 * D) - tri_n(l - 3 * D));
        end
        return acc;
    endfunction

    task automatic model_clear();
        e = 0;
        ui.delete();
        uq.delete();
        hist.delete();
        exp_v = 1'b0;
        exp_i = '0;
        exp_q = '0;
    endtask

    // advance one clock and update the model; product for edge k comes from inputs two edges earlier
    task automatic step();
        logic [2:0] h;
        @(posedge clk);
        #1;
        e++;
        hist.push_back({rf_in, lo_sin, lo_cos});
        if (e == 1) begin
            ui.push_back(-1);
            uq.push_back(-1);
        end else if (e == 2) begin
            ui.push_back(1);
            uq.push_back(1);
        end else begin
            h = hist[e-3];
            ui.push_back(h[2] == h[0] ? 1 : -1);
            uq.push_back(h[2] == h[1] ? 1 : -1);
        end
        exp_v = (e >= 4 * D + 3) && ((e - 3) % D == 0);
        if (exp_v) begin
            exp_i = OW'(cic((e - 3) / D, 1'b0));
            exp_q = OW'(cic((e - 3) / D, 1'b1));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        if (i_out !== '0) begin errors++; $display("FAIL reset_i got %0d exp 0", i_out); end
        if (q_out !== '0) begin errors++; $display("FAIL reset_q got %0d exp 0", q_out); end
        model_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_constant(input string nm, input logic rf, input logic sn, input logic cs,
                                 input logic signed [OW-1:0] ci, input logic signed [OW-1:0] cq, input int cycles);
        int nval = 0;
        do_reset();
        rf_in = rf; lo_sin = sn; lo_cos = cs;
        for (int c = 0; c < cycles; c++) begin
            step();
            checks += 3;
            if (out_valid !== exp_v) begin errors++; $display("FAIL %s_valid e=%0d got %b exp %b", nm, e, out_valid, exp_v); end
            if (i_out !== exp_i) begin errors++; $display("FAIL %s_i e=%0d got %0d exp %0d", nm, e, i_out, $signed(exp_i)); end
            if (q_out !== exp_q) begin errors++; $display("FAIL %s_q e=%0d got %0d exp %0d", nm, e, q_out, $signed(exp_q)); end
            if (exp_v) begin
                nval++;
                if (nval >= 2) begin
                    checks += 2;
                    if (i_out !== ci) begin errors++; $display("FAIL %s_i_const e=%0d got %0d exp %0d", nm, e, i_out, ci); end
                    if (q_out !== cq) begin errors++; $display("FAIL %s_q_const e=%0d got %0d exp %0d", nm, e, q_out, cq); end
                end
            end
        end
    endtask

    task automatic test_nyquist();
        int nval = 0;
        do_reset();
        lo_sin = 1'b1; lo_cos = 1'b1; rf_in = 1'b0;
        for (int c = 0; c < 80; c++) begin
            rf_in = ~rf_in;
            step();
            checks += 3;
            if (out_valid !== exp_v) begin errors++; $display("FAIL nyq_valid e=%0d got %b exp %b", e, out_valid, exp_v); end
            if (i_out !== exp_i) begin errors++; $display("FAIL nyq_i e=%0d got %0d exp %0d", e, i_out, $signed(exp_i)); end
            if (q_out !== exp_q) begin errors++; $display("FAIL nyq_q e=%0d got %0d exp %0d", e, q_out, $signed(exp_q)); end
            if (exp_v) begin
                nval++;
                if (nval >= 2) begin
                    checks += 2;
                    if (i_out !== '0) begin errors++; $display("FAIL nyq_i_null e=%0d got %0d exp 0", e, i_out); end
                    if (q_out !== '0) begin errors++; $display("FAIL nyq_q_null e=%0d got %0d exp 0", e, q_out); end
                end
            end
        end
    endtask

    task automatic test_strobe_timing();
        int first = 0;
        int last = 0;
        int cnt = 0;
        do_reset();
        for (int c = 0; c < 80; c++) begin
            {rf_in, lo_sin, lo_cos} = 3'($urandom);
            step();
            if (out_valid === 1'b1) begin
                cnt++;
                if (first == 0) first = e;
                else begin
                    checks++;
                    if (e - last != D) begin errors++; $display("FAIL strobe_period e=%0d got %0d exp %0d", e, e - last, D); end
                end
                last = e;
            end
        end
        checks += 2;
        if (first != 4 * D + 3) begin errors++; $display("FAIL strobe_first got %0d exp %0d", first, 4 * D + 3); end
        if (cnt != 6) begin errors++; $display("FAIL strobe_count got %0d exp 6", cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            {rf_in, lo_sin, lo_cos} = 3'($urandom);
            step();
            checks += 3;
            if (out_valid !== exp_v) begin errors++; $display("FAIL rnd_valid e=%0d got %b exp %b", e, out_valid, exp_v); end
            if (i_out !== exp_i) begin errors++; $display("FAIL rnd_i e=%0d got %0d exp %0d", e, i_out, $signed(exp_i)); end
            if (q_out !== exp_q) begin errors++; $display("FAIL rnd_q e=%0d got %0d exp %0d", e, q_out, $signed(exp_q)); end
        end
    endtask

    task automatic test_mid_reset();
        int nval = 0;
        do_reset();
        rf_in = 1'b1; lo_sin = 1'b0; lo_cos = 1'b1;
        repeat (7 * D + 3) step();
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", out_valid); end
        if (i_out !== 11'sd512) begin errors++; $display("FAIL mid_pre_i got %0d exp 512", i_out); end
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", out_valid); end
        if (i_out !== '0) begin errors++; $display("FAIL mid_i got %0d exp 0", i_out); end
        if (q_out !== '0) begin errors++; $display("FAIL mid_q got %0d exp 0", q_out); end
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 80; c++) begin
            step();
            checks += 3;
            if (out_valid !== exp_v) begin errors++; $display("FAIL mid_post_valid e=%0d got %b exp %b", e, out_valid, exp_v); end
            if (i_out !== exp_i) begin errors++; $display("FAIL mid_post_i e=%0d got %0d exp %0d", e, i_out, $signed(exp_i)); end
            if (q_out !== exp_q) begin errors++; $display("FAIL mid_post_q e=%0d got %0d exp %0d", e, q_out, $signed(exp_q)); end
            if (exp_v) begin
                nval++;
                if (nval >= 2) begin
                    checks += 2;
                    if (i_out !== 11'sd512) begin errors++; $display("FAIL mid_i_const e=%0d got %0d exp 512", e, i_out); end
                    if (q_out !== -11'sd512) begin errors++; $display("FAIL mid_q_const e=%0d got %0d exp -512", e, q_out); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_constant("case1", 1'b1, 1'b0, 1'b1, 11'sd512, -11'sd512, 80);
        test_constant("case2", 1'b0, 1'b1, 1'b1, -11'sd512, -11'sd512, 80);
        test_nyquist();
        test_strobe_timing();
        test_constant("wrap", 1'b1, 1'b0, 1'b1, 11'sd512, -11'sd512, 5000);
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
